// File: rtl/vga_pkg.sv
// Shared display package for the pixel memory arbiter slice.
// Holds frame geometry, the arbiter FSM state type and a small helper.
package vga_pkg;

    localparam int H_DISP       = 1280;
    localparam int V_DISP       = 1024;
    localparam int FRAME_PIXELS = H_DISP * V_DISP;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RD_BURST,
        ST_RD_DRAIN,
        ST_WR
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pixel_mem_arbiter_if.sv
// Bus bundle between the arbiter, the pixel FIFO, the writer and memory.
// master = arbiter side, slave = environment side.
interface pixel_mem_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8,
    parameter int FREE_W = 8
);

    logic [FREE_W-1:0] fifo_free;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_flush;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  fifo_free,
        output fifo_wr,
        output fifo_wdata,
        output fifo_flush,
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output fifo_free,
        input  fifo_wr,
        input  fifo_wdata,
        input  fifo_flush,
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/pix_rd_pipe.sv
// Read-valid pipeline: tags each memory read and raises the FIFO push
// when its data returns, MEM_LAT cycles later.
module pix_rd_pipe #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic fifo_wr,
    output logic in_flight
);

    logic [MEM_LAT-1:0] vld;

    // shift the read tag along with the memory latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign fifo_wr   = vld[MEM_LAT-1];
    assign in_flight = |vld;

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Pixel memory arbiter: burst prefetch for scan-out, gap writes for drawing.
// Optional underrun counter: define PIX_ARB_UNDERRUN_EN.
module pixel_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 8,
    parameter int BURST   = 16,
    parameter int MEM_LAT = 2,
    parameter int FREE_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
`ifdef PIX_ARB_UNDERRUN_EN
    input  logic        disp_enable,
    input  logic        fifo_empty,
    output logic [15:0] underrun_cnt,
`endif
    pixel_mem_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(max_int(BURST, MEM_LAT));

    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [FREE_W:0]   BURST_NEED = (FREE_W + 1)'(BURST);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic              pend_q;
    logic              pend_d;
    logic              last_rd_q;
    logic              last_rd_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              wr_ack_c;
    logic              flush_c;

    logic              free_ok;
    logic              wr_in_range;
    logic              rd_issue;
    logic              rd_vld;
    logic              in_flight;

    assign free_ok     = {1'b0, bus.fifo_free} >= BURST_NEED;
    assign wr_in_range = bus.wr_addr <= PIX_LAST;
    assign rd_issue    = state_q == ST_RD_BURST;

    pix_rd_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (rd_issue),
        .fifo_wr   (rd_vld),
        .in_flight (in_flight)
    );

    // arbiter state, read pointer, pending frame and grant history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr    <= '0;
            pend_q    <= 1'b0;
            last_rd_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr    <= rd_ptr_d;
            pend_q    <= pend_d;
            last_rd_q <= last_rd_d;
            cnt_q     <= cnt_d;
        end
    end

    // grant decision and memory/FIFO strobes
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr;
        pend_d      = pend_q | frame_start;
        last_rd_d   = last_rd_q;
        cnt_d       = cnt_q;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        wr_ack_c    = 1'b0;
        flush_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!in_flight) begin
                    if (pend_q || frame_start) begin
                        state_d = ST_FLUSH;
                    end else if (bus.wr_req && last_rd_q) begin
                        state_d   = ST_WR;
                        last_rd_d = 1'b0;
                    end else if (free_ok) begin
                        state_d   = ST_RD_BURST;
                        last_rd_d = 1'b1;
                        cnt_d     = '0;
                    end else if (bus.wr_req) begin
                        state_d   = ST_WR;
                        last_rd_d = 1'b0;
                    end
                end
            end

            ST_FLUSH: begin
                flush_c  = 1'b1;
                rd_ptr_d = '0;
                pend_d   = frame_start;
                state_d  = ST_IDLE;
            end

            ST_RD_BURST: begin
                mem_en_c   = 1'b1;
                mem_addr_c = rd_ptr;
                rd_ptr_d   = (rd_ptr == PIX_LAST) ? '0 : rd_ptr + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == BURST_LAST) begin
                    state_d = ST_RD_DRAIN;
                    cnt_d   = '0;
                end
            end

            ST_RD_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_WR: begin
                wr_ack_c = 1'b1;
                if (wr_in_range) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = 1'b1;
                    mem_addr_c  = bus.wr_addr;
                    mem_wdata_c = bus.wr_data;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_en     = mem_en_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.wr_ack     = wr_ack_c;
    assign bus.fifo_flush = flush_c;
    assign bus.fifo_wr    = rd_vld;
    assign bus.fifo_wdata = rd_vld ? bus.mem_rdata : '0;

`ifdef PIX_ARB_UNDERRUN_EN
    // saturating count of cycles the display starved
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == ST_FLUSH) begin
            underrun_cnt <= '0;
        end else if (disp_enable && fifo_empty && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter with a latency-accurate memory model.
// Covers bursts, wrap, write interleave, frame flush, drops and reset.
module tb_pixel_mem_arbiter;

    localparam int AW      = 21;
    localparam int DW      = 8;
    localparam int BURST   = 16;
    localparam int MEM_LAT = 2;
    localparam int FW      = 8;
    localparam int FRAME   = 1280 * 1024;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        int            cyc;
    } strobe_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } push_t;

    logic clk;
    logic rst_n;
    logic frame_start;
`ifdef PIX_ARB_UNDERRUN_EN
    logic        disp_enable;
    logic        fifo_empty;
    logic [15:0] underrun_cnt;
`endif

    pixel_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FREE_W(FW)) bus ();

    pixel_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .BURST   (BURST),
        .MEM_LAT (MEM_LAT),
        .FREE_W  (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
`ifdef PIX_ARB_UNDERRUN_EN
        .disp_enable  (disp_enable),
        .fifo_empty   (fifo_empty),
        .underrun_cnt (underrun_cnt),
`endif
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    strobe_t strobes[$];
    push_t   pushes[$];
    int      flushes[$];
    int      acks[$];

    logic [DW-1:0] wmem [int];
    logic [DW-1:0] rpipe [MEM_LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return pat(a);
    endfunction

    // memory model: fixed read latency, writes land at the edge
    always @(posedge clk) begin
        logic [DW-1:0] d;
        d = rd_word(bus.mem_addr);
        if (bus.mem_en && bus.mem_we) wmem[int'(bus.mem_addr)] = bus.mem_wdata;
        rpipe[0] <= d;
        for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign bus.mem_rdata = rpipe[MEM_LAT-1];

    // event log sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_en) strobes.push_back('{bus.mem_addr, bus.mem_we, cyc});
        if (bus.fifo_wr) pushes.push_back('{bus.fifo_wdata, cyc});
        if (bus.fifo_flush) flushes.push_back(cyc);
        if (bus.wr_ack) acks.push_back(cyc);
    end

    function automatic logic [63:0] outs();
        return 64'({bus.fifo_wr, bus.fifo_wdata, bus.fifo_flush, bus.wr_ack,
                    bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        strobes.delete();
        pushes.delete();
        flushes.delete();
        acks.delete();
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int b = budget;
        while (strobes.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 64'(strobes.size() >= n), 64'(1));
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int b = budget;
        while (acks.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 64'(acks.size() >= n), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cyc;
        int nrd;
        int nwr;
        int npre;

        rst_n         = 1'b0;
        frame_start   = 1'b0;
        bus.fifo_free = '0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
`ifdef PIX_ARB_UNDERRUN_EN
        disp_enable   = 1'b0;
        fifo_empty    = 1'b0;
`endif

        // reset state
        tick();
        tick();
        chk("reset_outs", outs(), 64'(0));

        // two back-to-back bursts from address 0
        rst_n = 1'b1;
        clr();
        bus.fifo_free = 8'd64;
        wait_strobes("b2b_wait", 32, 100);
        bus.fifo_free = '0;
        repeat (25) tick();
        chk("b2b_nstrobe", 64'(strobes.size()), 64'(32));
        chk("b2b_npush", 64'(pushes.size()), 64'(32));
        chk("b2b_a0", 64'(strobes[0].addr), 64'(0));
        chk("b2b_a15", 64'(strobes[15].addr), 64'(15));
        chk("b2b_a16", 64'(strobes[16].addr), 64'(16));
        chk("b2b_a31", 64'(strobes[31].addr), 64'(31));
        chk("b2b_we", 64'(strobes[0].we | strobes[31].we), 64'(0));
        chk("b2b_lat", 64'(pushes[0].cyc - strobes[0].cyc), 64'(MEM_LAT));
        chk("b2b_span", 64'(pushes[15].cyc - pushes[0].cyc), 64'(15));
        chk("b2b_gap", 64'(strobes[16].cyc - strobes[15].cyc), 64'(4));
        for (int i = 0; i < 32 && i < pushes.size(); i++)
            chk("b2b_data", 64'(pushes[i].data), 64'(pat(AW'(i))));

        // burst wrapping at the end of the frame
        force dut.rd_ptr = 21'(FRAME - 8);
        tick();
        release dut.rd_ptr;
        clr();
        bus.fifo_free = 8'(BURST);
        wait_strobes("wrap_wait", 1, 10);
        bus.fifo_free = '0;
        repeat (25) tick();
        chk("wrap_nstrobe", 64'(strobes.size()), 64'(16));
        chk("wrap_npush", 64'(pushes.size()), 64'(16));
        chk("wrap_a0", 64'(strobes[0].addr), 64'(FRAME - 8));
        chk("wrap_a7", 64'(strobes[7].addr), 64'(FRAME - 1));
        chk("wrap_a8", 64'(strobes[8].addr), 64'(0));
        chk("wrap_a15", 64'(strobes[15].addr), 64'(7));
        for (int i = 0; i < 16 && i < pushes.size(); i++)
            chk("wrap_data", 64'(pushes[i].data), 64'(pat(AW'((FRAME - 8 + i) % FRAME))));

        // writes interleaved with continuous fetch
        clr();
        bus.fifo_free = 8'd255;
        repeat (3) tick();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 21'd100;
        bus.wr_data = 8'hC3;
        req_cyc = cyc;
        wait_acks("wr1_wait", 1, 40);
        chk("wr1_lat", 64'((acks[0] - req_cyc) <= BURST + MEM_LAT + 3), 64'(1));
        tick();
        bus.wr_addr = 21'd200;
        bus.wr_data = 8'h3C;
        req_cyc = cyc;
        wait_acks("wr2_wait", 2, 40);
        bus.wr_req = 1'b0;
        bus.fifo_free = '0;
        repeat (25) tick();
        nrd = 0;
        nwr = 0;
        foreach (strobes[i]) begin
            if (strobes[i].we) nwr++;
            if (acks.size() >= 2 && !strobes[i].we &&
                strobes[i].cyc > acks[0] && strobes[i].cyc < acks[1]) nrd++;
        end
        chk("wr2_lat", 64'((acks[1] - req_cyc) <= BURST + MEM_LAT + 3), 64'(1));
        chk("wr_nack", 64'(acks.size()), 64'(2));
        chk("wr_nwr", 64'(nwr), 64'(2));
        chk("wr_alt_reads", 64'(nrd), 64'(BURST));
        chk("wr_mem100", 64'(rd_word(21'd100)), 64'(8'hC3));
        chk("wr_mem200", 64'(rd_word(21'd200)), 64'(8'h3C));

        // frame start during burst cycle 5
        clr();
        bus.fifo_free = 8'd255;
        wait_strobes("fs_wait5", 5, 40);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_strobes("fs_wait17", 17, 60);
        bus.fifo_free = '0;
        repeat (25) tick();
        npre = 0;
        foreach (pushes[i])
            if (flushes.size() > 0 && pushes[i].cyc < flushes[0]) npre++;
        chk("fs_nflush", 64'(flushes.size()), 64'(1));
        chk("fs_flush_at", 64'(flushes[0] - strobes[15].cyc), 64'(4));
        chk("fs_pre_push", 64'(npre), 64'(16));
        chk("fs_restart", 64'(strobes[16].addr), 64'(0));
        chk("fs_restart_at", 64'(strobes[16].cyc - flushes[0]), 64'(2));

        // out-of-range write is dropped but acked
        clr();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 21'(FRAME);
        bus.wr_data = 8'hEE;
        wait_acks("oor_wait", 1, 40);
        bus.wr_req = 1'b0;
        repeat (3) tick();
        chk("oor_nack", 64'(acks.size()), 64'(1));
        chk("oor_nostrobe", 64'(strobes.size()), 64'(0));

        // last in-range address is written
        clr();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 21'(FRAME - 1);
        bus.wr_data = 8'h77;
        wait_acks("top_wait", 1, 40);
        bus.wr_req = 1'b0;
        repeat (3) tick();
        chk("top_nstrobe", 64'(strobes.size()), 64'(1));
        chk("top_we", 64'(strobes[0].we), 64'(1));
        chk("top_addr", 64'(strobes[0].addr), 64'(FRAME - 1));
        chk("top_mem", 64'(rd_word(21'(FRAME - 1))), 64'(8'h77));

        // reset in the middle of a burst
        clr();
        bus.fifo_free = 8'd64;
        wait_strobes("rst_wait", 6, 40);
        rst_n = 1'b0;
        tick();
        chk("rst_outs", outs(), 64'(0));
        clr();
        bus.fifo_free = '0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_npush", 64'(pushes.size()), 64'(0));
        chk("rst_nstrobe", 64'(strobes.size()), 64'(0));

`ifdef PIX_ARB_UNDERRUN_EN
        // starved display counts one per cycle
        chk("und_zero", 64'(underrun_cnt), 64'(0));
        disp_enable = 1'b1;
        fifo_empty  = 1'b1;
        repeat (10) tick();
        disp_enable = 1'b0;
        fifo_empty  = 1'b0;
        chk("und_cnt", 64'(underrun_cnt), 64'(10));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_mem_arbiter.md
# pixel_mem_arbiter

Shares the single-port pixel memory between display scan-out and a drawing-side writer. Prefetches pixels in fixed-size bursts into the downstream pixel FIFO, which feeds the pixel mux gated by `disp_enable`. Grants single-word writes to the drawing engine in the gaps between bursts. Restarts the read pointer at every frame start so the scan-out stays locked to the timing generator.

## Interface
- `H_DISP`, 1280, visible pixels per line
- `V_DISP`, 1024, visible lines per frame
- `ADDR_W`, 21, memory address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP
- `DATA_W`, 8, pixel width
- `BURST`, 16, reads per fetch burst (power of two, >= 2)
- `MEM_LAT`, 2, fixed memory read latency in cycles (>= 1)
- `FREE_W`, 8, width of `fifo_free`
---
- `clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  synchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse at the start of the vertical sync
- `fifo_free`  in  FREE_W  free slots in the pixel FIFO; must reflect `fifo_wr` in the same cycle
- `fifo_wr`  out  1  push `fifo_wdata` into the pixel FIFO
- `fifo_wdata`  out  DATA_W  pixel read from memory
- `fifo_flush`  out  1  one-cycle FIFO clear
- `wr_req`  in  1  writer request; held until acked
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `wr_ack`  out  1  one-cycle pulse: write accepted or dropped
- `mem_en`, `mem_we`  out  1 each  memory strobe, write select
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data, valid MEM_LAT cycles after a read strobe

## Operation
- FSM states:
  - IDLE
  - FLUSH: 1 cycle
  - RD_BURST: exactly BURST cycles
  - RD_DRAIN: MEM_LAT cycles
  - WR: 1 cycle
- IDLE decision order:
  - (1) frame_start pending -> FLUSH
  - (2) `wr_req` and the last grant was a read -> WR
  - (3) `fifo_free >= BURST` -> RD_BURST
  - (4) `wr_req` -> WR
  - (5) otherwise stay in IDLE
- FLUSH: `fifo_flush`=1 and read pointer := 0; clears the pending flag.
- RD_BURST: `mem_en`=1, `mem_we`=0, `mem_addr`=read pointer; pointer increments each cycle and wraps from H_DISP*V_DISP-1 to 0.
- A MEM_LAT-deep valid shift register tags each read. Its output drives `fifo_wr`, with `fifo_wdata`=`mem_rdata`.
- RD_DRAIN: waits until the valid pipe is empty. No new burst or write may issue while reads are in flight.
- WR:
  - If `wr_addr` < H_DISP*V_DISP: `mem_en`=`mem_we`=1 and `mem_addr`/`mem_wdata` taken from the writer.
  - If `wr_addr` is out of range: no strobe; the write is dropped.
  - `wr_ack`=1 in both cases.
- `frame_start` arriving in any state sets the pending flag. The current burst or write completes first; no burst is truncated.
- After FLUSH, the valid pipe is empty by construction, so no stale pixel reaches the FIFO.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - state IDLE, pointer 0, pending flag 0, valid pipe 0, last-grant = write
  - all outputs 0
- Reset mid-burst discards in-flight reads; no `fifo_wr` follows the reset.
- Burst latency: first `fifo_wr` arrives MEM_LAT cycles after the first `mem_en`. BURST consecutive `fifo_wr`.
- Worst-case `wr_ack` latency from `wr_req` rising: BURST+MEM_LAT+3 cycles (one burst plus FLUSH).
- `wr_ack` asserts in the WR cycle. The writer changes address/data only after seeing `wr_ack`.
- A `frame_start` coincident with the IDLE decision is taken before any request.

## Configuration
- `PIX_ARB_UNDERRUN_EN`, when defined:
  - Adds input `disp_enable` (1), input `fifo_empty` (1) and output `underrun_cnt` (16).
  - The counter increments each cycle with `disp_enable && fifo_empty`, saturates at 16'hFFFF, and clears on reset and in FLUSH.
- Undefined: these ports and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `vga_pkg`:
  - display constants H_DISP, V_DISP, FRAME_PIXELS = H_DISP*V_DISP
  - FSM state enum `arb_state_t`
- Sub-module `pix_rd_pipe`: the MEM_LAT valid shift register producing `fifo_wr` and an `in_flight` flag.

## Test plan
- Reset, then `fifo_free`=64 with no writer: bursts at addresses 0..15, then 16..31. `fifo_wr` starts at cycle MEM_LAT after the first strobe; `fifo_wdata` matches the memory model.
- Pointer at FRAME_PIXELS-8 with BURST=16: the burst wraps to 0 after address 1310719; 16 pushes in order.
- `wr_req` held during continuous fetch (`fifo_free`=255): the write and burst grants alternate. `wr_ack` ≤ BURST+MEM_LAT+3 cycles after the request; memory holds `wr_data` at `wr_addr`.
- `frame_start` in burst cycle 5: the burst completes 16 reads, drains, then FLUSH pulses one cycle. The next burst starts at address 0.
- `wr_addr`=FRAME_PIXELS: `wr_ack` pulses with no `mem_en`. `rst_n`=0 mid-burst: all outputs 0 the next cycle; no `fifo_wr` afterwards.
- With `PIX_ARB_UNDERRUN_EN`: hold `fifo_free`<BURST for 10 cycles with `disp_enable`=`fifo_empty`=1 -> `underrun_cnt`=10.
